// File: rtl/camera_pattern_tx.sv
// Camera-style test pattern source: emits FVAL/LVAL/12-bit data framing at clk/2 with
// selectable ramp, checkerboard or frame-count patterns.
module camera_pattern_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned FV_LEAD  = 16,
  parameter int unsigned FV_TRAIL = 16,
  parameter int unsigned V_BLANK  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        pixclk,
  output logic        fval,
  output logic        lval,
  output logic [11:0] d,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] LeadLast  = 32'(FV_LEAD - 1);
  localparam logic [31:0] HbLast    = 32'(H_BLANK - 1);
  localparam logic [31:0] TrailLast = 32'(FV_TRAIL - 1);
  localparam logic [31:0] VbLast    = 32'(V_BLANK - 1);
  localparam logic [15:0] XLast     = 16'(H_ACTIVE - 1);
  localparam logic [15:0] YLast     = 16'(V_ACTIVE - 1);

  typedef enum logic [2:0] {StIdle, StLead, StLine, StHblank, StTrail, StVblank} state_e;

  state_e      state_q, state_d;
  logic        pix_q;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [1:0]  mode_q, mode_d;
  logic        fval_q, fval_d, lval_q, lval_d;
  logic [11:0] d_q, d_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  function automatic logic [11:0] pattern(input logic [1:0]  m,
                                          input logic [15:0] px,
                                          input logic [15:0] py,
                                          input logic [15:0] fc);
    case (m)
      2'd0:    pattern = px[11:0];
      2'd1:    pattern = py[11:0];
      2'd2:    pattern = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
      default: pattern = {4'h0, fc[7:0]};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    fval_d  = fval_q;
    lval_d  = lval_q;
    d_d     = d_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    // pix_q high means this edge drives pixclk low: the only edge on which framing moves
    if (pix_q) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d = StLead;
            mode_d  = mode;
            fval_d  = 1'b1;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
          end
        end
        StLead: begin
          if (cnt_q == LeadLast) begin
            state_d = StLine;
            lval_d  = 1'b1;
            x_d     = '0;
            d_d     = pattern(mode_q, 16'd0, y_q, fcnt_q);
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StLine: begin
          if (x_q == XLast) begin
            lval_d  = 1'b0;
            d_d     = '0;
            cnt_d   = '0;
            state_d = (y_q == YLast) ? StTrail : StHblank;
          end else begin
            x_d = x_q + 16'd1;
            d_d = pattern(mode_q, x_q + 16'd1, y_q, fcnt_q);
          end
        end
        StHblank: begin
          if (cnt_q == HbLast) begin
            state_d = StLine;
            lval_d  = 1'b1;
            x_d     = '0;
            y_d     = y_q + 16'd1;
            d_d     = pattern(mode_q, 16'd0, y_q + 16'd1, fcnt_q);
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StTrail: begin
          if (cnt_q == TrailLast) begin
            state_d = StVblank;
            fval_d  = 1'b0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StVblank: begin
          if (cnt_q == VbLast) begin
            if (enable) begin
              state_d = StLead;
              mode_d  = mode;
              fval_d  = 1'b1;
              cnt_d   = '0;
              x_d     = '0;
              y_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pix_q   <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= ~pix_q;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pixclk     = pix_q;
  assign fval       = fval_q;
  assign lval       = lval_q;
  assign d          = d_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_camera_pattern_tx.sv
// Scoreboard bench for camera_pattern_tx: a per-tick frame-position model predicts every
// output; a monitor compares on every clk falling edge, including between ticks.
module tb_camera_pattern_tx;

  localparam int H  = 16;
  localparam int V  = 10;
  localparam int HB = 2;
  localparam int FL = 1;
  localparam int FT = 1;
  localparam int VB = 3;
  localparam int FrameLen = FL + V * H + (V - 1) * HB + FT;

  typedef struct packed {
    logic        fval;
    logic        lval;
    logic [11:0] d;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        pixclk, fval, lval, busy, frame_done;
  logic [11:0] d;
  logic [15:0] frame_cnt;

  camera_pattern_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .FV_LEAD(FL), .FV_TRAIL(FT), .V_BLANK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .pixclk(pixclk),
    .fval(fval), .lval(lval), .d(d), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Bench's own view of the pixel clock phase
  logic ph;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ph <= 1'b0;
    else          ph <= ~ph;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t cur = '0;
  bit   checking = 1'b0;

  // Model state: frame position is plain arithmetic on the tick index
  int          m_tick = 0;
  int          m_start = 0;
  bit          m_active = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_fcnt = 16'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] pat(input logic [1:0] m, input int x, input int y,
                                      input logic [15:0] fc);
    case (m)
      2'd0:    return 12'(x % 4096);
      2'd1:    return 12'(y % 4096);
      2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
      default: return 12'(fc % 256);
    endcase
  endfunction

  task automatic model_tick(input bit en, input logic [1:0] md);
    exp_t e;
    int p, q, line, col;
    if (!m_active) begin
      if (en) begin m_active = 1'b1; m_start = m_tick; m_mode = md; end
    end else if (m_tick - m_start == FrameLen + VB) begin
      if (en) begin m_start = m_tick; m_mode = md; end
      else m_active = 1'b0;
    end
    e = '0;
    if (m_active) begin
      p = m_tick - m_start;
      e.busy = 1'b1;
      if (p == FrameLen) begin m_fcnt = m_fcnt + 16'd1; e.frame_done = 1'b1; end
      if (p < FrameLen) begin
        e.fval = 1'b1;
        q = p - FL;
        if (q >= 0 && q < V * (H + HB)) begin
          line = q / (H + HB);
          col  = q % (H + HB);
          if (col < H) begin
            e.lval = 1'b1;
            e.d    = pat(m_mode, col, line, m_fcnt);
          end
        end
      end
    end
    e.frame_cnt = m_fcnt;
    sb_q.push_back(e);
    m_tick++;
  endtask

  // Drive inputs during pixclk-high half, then let the tick edge happen
  task automatic do_tick(input bit en, input logic [1:0] md);
    @(negedge clk);
    while (ph != 1'b1) @(negedge clk);
    enable = en;
    mode   = md;
    @(posedge clk);
    #1;
    model_tick(en, md);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      if (!reset_n) cur = '0;
      else if (ph == 1'b0 && sb_q.size() > 0) cur = sb_q.pop_front();
      else cur.frame_done = 1'b0;
      chk("pixclk", int'(pixclk), int'(ph));
      chk("fval", int'(fval), int'(cur.fval));
      chk("lval", int'(lval), int'(cur.lval));
      chk("d", int'(d), int'(cur.d));
      chk("busy", int'(busy), int'(cur.busy));
      chk("frame_done", int'(frame_done), int'(cur.frame_done));
      chk("frame_cnt", int'(frame_cnt), int'(cur.frame_cnt));
      chk("lval_implies_fval", int'(lval & ~fval), 0);
    end
  end

  initial begin
    #2;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Single frame from a one-tick enable pulse, then idle
    do_tick(1'b1, 2'd0);
    repeat (FrameLen + VB + 10) do_tick(1'b0, 2'd0);

    // Back-to-back checkerboard frames
    repeat (2 * (FrameLen + VB) + 5) do_tick(1'b1, 2'd2);

    // Mode switched 0 -> 1 mid-frame
    repeat (FrameLen + VB) do_tick(1'b1, 2'd0);
    repeat (FrameLen / 2) do_tick(1'b1, 2'd0);
    repeat (FrameLen + VB + 40) do_tick(1'b1, 2'd1);

    // Randomized enable and mode every tick
    repeat (1200) do_tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));

    // Drain to idle, start a frame, reset during the first line
    repeat (FrameLen + VB + 2) do_tick(1'b0, 2'd3);
    do_tick(1'b1, 2'd3);
    repeat (FL + 3) do_tick(1'b0, 2'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_fval", int'(fval), 0);
    chk("rst_lval", int'(lval), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    sb_q.delete();
    m_active = 1'b0;
    m_fcnt   = 16'd0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Clean restart after reset, then a mode-3 stretch
    repeat (2 * (FrameLen + VB) + 10) do_tick(1'b1, 2'd3);

    @(negedge clk);
    @(negedge clk);
    checking = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_pattern_tx.md
CAMERA_PATTERN_TX -- requirements
Module: camera_pattern_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line (>=2).
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame (>=1).
REQ-003 Parameter H_BLANK, default 64, pixel periods LVAL low between lines within a frame (>=1).
REQ-004 Parameter FV_LEAD, default 16, pixel periods from FVAL rise to first LVAL rise (>=1).
REQ-005 Parameter FV_TRAIL, default 16, pixel periods from last LVAL fall to FVAL fall (>=1).
REQ-006 Parameter V_BLANK, default 1024, pixel periods FVAL low between frames (>=1).
REQ-007 clk  in  1  system clock; pixel rate is clk/2.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  level request to emit frames.
REQ-010 mode  in  2  pattern select, latched at frame start.
REQ-011 pixclk  out  1  camera pixel clock, clk divided by 2.
REQ-012 fval  out  1  frame valid.
REQ-013 lval  out  1  line valid.
REQ-014 d  out  12  pixel data.
REQ-015 busy  out  1  high from FVAL rise through end of trailing V_BLANK.
REQ-016 frame_done  out  1  one-clk pulse when fval falls.
REQ-017 frame_cnt  out  16  completed-frame count.

Function
REQ-018 pixclk toggles every clk; fval, lval and d update only on the clk edge where pixclk goes low, so a receiver sampling on pixclk rising sees half a pixel period of setup and hold.
REQ-019 One "pixel tick" = one pixclk period; every duration below is in ticks.
REQ-020 FSM states: IDLE, LEAD, LINE, HBLANK, TRAIL, VBLANK; all outputs are registered.
REQ-021 IDLE: fval=lval=0, d=0; if enable=1 at a tick, go to LEAD on that tick, latch mode, set fval=1, x=0, y=0.
REQ-022 LEAD: hold for FV_LEAD ticks, then go to LINE with lval=1.
REQ-023 LINE: lval=1 for exactly H_ACTIVE ticks; x goes from 0 to H_ACTIVE-1 and d carries the pattern value for (x,y).
REQ-024 After the last pixel: if y<V_ACTIVE-1, go to HBLANK (lval=0, d=0) for H_BLANK ticks, then y+1, x=0, back to LINE; otherwise go to TRAIL.
REQ-025 TRAIL: lval=0, fval=1 for FV_TRAIL ticks; at the end, fval=0, frame_done pulses, frame_cnt increments (wraps 0xFFFF->0), go to VBLANK.
REQ-026 VBLANK: fval=0 for V_BLANK ticks; at the end, if enable=1 go directly to LEAD (new frame, mode re-latched), else go to IDLE.
REQ-027 enable deasserted mid-frame has no effect until the frame and its V_BLANK complete; a frame is never truncated.
REQ-028 mode changes mid-frame are ignored until the next frame start.
REQ-029 Pattern mode 0: d = x[11:0] (horizontal ramp, wraps mod 4096).
REQ-030 Pattern mode 1: d = y[11:0] (vertical ramp).
REQ-031 Pattern mode 2: checkerboard; d = 12'hFFF when x[3]^y[3]=1, else 12'h000.
REQ-032 Pattern mode 3: d = {4'h0, frame_cnt[7:0]} (constant per frame; value before increment).
REQ-033 d=0 whenever lval=0.
REQ-034 Frame length is FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + FV_TRAIL ticks of fval=1.

Reset
REQ-035 While reset_n=0: pixclk=0, fval=0, lval=0, d=0, busy=0, frame_done=0, frame_cnt=0, and the FSM is in IDLE.
REQ-036 Reset asserted mid-frame takes effect immediately, with no frame completion and no frame_done.
REQ-037 After reset_n rises, the first frame starts no earlier than the first pixclk-low edge with enable=1.

Verification
REQ-038 Params H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, FV_LEAD=1, FV_TRAIL=1, V_BLANK=3; mode 0, enable pulsed for one tick -> one frame only: fval high for 12 ticks, two lval bursts of 4 ticks with d=0,1,2,3, frame_cnt=1, then IDLE.
REQ-039 Same params, enable held high -> back-to-back frames with exactly 3 ticks fval low between them; frame_done pulses once per frame.
REQ-040 Mode 2, H_ACTIVE=16, V_ACTIVE=16 -> row 0: d=000 for x 0-7 and FFF for x 8-15; row 8 is inverted.
REQ-041 Mode changed from 0 to 1 mid-frame -> current frame stays mode 0; next frame shows d=y.
REQ-042 reset_n pulsed low during LINE -> all outputs 0 at once, frame_cnt=0; a new frame starts cleanly at LEAD after release.
REQ-043 Checker on pixclk rising -> fval, lval and d never change within one clk of a pixclk rising edge; lval=1 only while fval=1.
